split_multiple_in_branch_dec: RTL

SPLIT_MULTIPLE_IN_BRANCH_DEC -- requirements
Module: split_multiple_in_branch_dec

---
 rtl/split_dec_pkg.sv | 27 ++
 rtl/split_dec_pipe_stage.sv | 27 ++
 rtl/split_multiple_in_branch_dec.sv | 72 +++++++
 3 files changed

// File: rtl/split_dec_pkg.sv
// rtl/split_dec_pkg.sv - shared constants, stage payload type and branch decode helper
package split_dec_pkg;

   localparam int DATA_W = 8;
   localparam logic [DATA_W-1:0] INV3 = 8'hAB;

   typedef struct packed {
      logic              cond;
      logic [DATA_W-1:0] x;
      logic [DATA_W-1:0] y;
   } stage_word_t;

   // Undo the encoder's conditioned branch; the result reuses x/y as the recovered a/b.
   function automatic stage_word_t decode_word(input stage_word_t w);
      stage_word_t d;
      d.cond = w.cond;
      if (w.cond) begin
         d.x = w.x * INV3;
         d.y = w.y - 8'd1;
      end else begin
         d.x = w.x;
         d.y = w.y;
      end
      return d;
   endfunction

endpackage

// File: rtl/split_dec_pipe_stage.sv
// rtl/split_dec_pipe_stage.sv - one valid/payload pipeline register
import split_dec_pkg::*;

module split_dec_pipe_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        advance,
   input  logic        in_valid,
   input  stage_word_t in_word,
   output logic        valid,
   output stage_word_t word
);

   // Payload only moves with a real word so a held output stays stable across bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         word  <= '0;
      end else if (advance) begin
         valid <= in_valid;
         if (in_valid) begin
            word <= in_word;
         end
      end
   end

endmodule

// File: rtl/split_multiple_in_branch_dec.sv
// rtl/split_multiple_in_branch_dec.sv - two-stage branch decoder with valid/ready flow control
import split_dec_pkg::*;

module split_multiple_in_branch_dec #(
   parameter int CNT_W = 16
) (
   input  logic              clk_j,
   input  logic              rst_n_j,
   input  logic              in_valid_j,
   output logic              in_ready_j,
   input  logic              condition_j,
   input  logic [DATA_W-1:0] enc_x_j,
   input  logic [DATA_W-1:0] enc_y_j,
   output logic              out_valid_j,
   input  logic              out_ready_j,
   output logic [DATA_W-1:0] dec_a_j,
   output logic [DATA_W-1:0] dec_b_j,
   output logic              dec_cond_j,
   output logic [CNT_W-1:0]  cond_cnt_j
);

   logic        s1_valid;
   logic        s2_valid;
   logic        s1_adv;
   logic        s2_adv;
   stage_word_t s1_in;
   stage_word_t s1_word;
   stage_word_t s2_in;
   stage_word_t s2_word;

   always_comb begin
      s2_adv     = !s2_valid || out_ready_j;
      s1_adv     = !s1_valid || s2_adv;
      in_ready_j = s1_adv;
      s1_in      = '{cond: condition_j, x: enc_x_j, y: enc_y_j};
      s2_in      = decode_word(s1_word);
   end

   split_dec_pipe_stage u_s1 (
      .clk      (clk_j),
      .rst_n    (rst_n_j),
      .advance  (s1_adv),
      .in_valid (in_valid_j),
      .in_word  (s1_in),
      .valid    (s1_valid),
      .word     (s1_word)
   );

   split_dec_pipe_stage u_s2 (
      .clk      (clk_j),
      .rst_n    (rst_n_j),
      .advance  (s2_adv),
      .in_valid (s1_valid),
      .in_word  (s2_in),
      .valid    (s2_valid),
      .word     (s2_word)
   );

   assign out_valid_j = s2_valid;
   assign dec_a_j     = s2_word.x;
   assign dec_b_j     = s2_word.y;
   assign dec_cond_j  = s2_word.cond;

   always_ff @(posedge clk_j or negedge rst_n_j) begin
      if (!rst_n_j) begin
         cond_cnt_j <= '0;
      end else if (out_valid_j && out_ready_j && dec_cond_j && (cond_cnt_j != '1)) begin
         cond_cnt_j <= cond_cnt_j + 1'b1;
      end
   end

endmodule
